// File: rtl/collatz_pkg.sv
// Shared types and widths for the Collatz predecessor enumerator.
package collatz_pkg;

    localparam int COLLATZ_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIV       = 2'd1,
        ST_EMIT_EVEN = 2'd2,
        ST_EMIT_ODD  = 2'd3
    } state_t;

endpackage

// File: rtl/collatz_div3.sv
// Iterative divide-by-3 of (m-1): one subtraction of 3 per enabled cycle.
module collatz_div3
    import collatz_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 en,
    input  logic [COLLATZ_W-1:0] m,
    output logic [COLLATZ_W-1:0] r,
    output logic [COLLATZ_W-1:0] q,
    output logic                 done
);

    logic [COLLATZ_W-1:0] r_q, r_d;
    logic [COLLATZ_W-1:0] q_q, q_d;

    always_comb begin
        r_d = r_q;
        q_d = q_q;
        if (start) begin
            r_d = m - 8'd1;
            q_d = '0;
        end else if (en && (r_q >= 8'd3)) begin
            r_d = r_q - 8'd3;
            q_d = q_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
            q_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
        end
    end

    assign r    = r_q;
    assign q    = q_q;
    assign done = (r_q < 8'd3);

endmodule

// File: rtl/collatz_pred.sv
// Enumerates the Collatz predecessors of m: always 2m, plus (m-1)/3 when that is an odd integer.
module collatz_pred
    import collatz_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COLLATZ_W-1:0] in_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLLATZ_W:0]   out_value,
    output logic                 out_kind,
    output logic                 out_last,
    output logic                 busy
);

    state_t               state_q, state_d;
    logic [COLLATZ_W-1:0] m_q, m_d;
    logic                 odd_ok_q, odd_ok_d;
    logic                 init_q, init_d;

    logic                 div_start;
    logic [COLLATZ_W-1:0] div_r;
    logic [COLLATZ_W-1:0] div_q;
    logic                 div_done;

    collatz_div3 u_div3 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (div_start),
        .en      (state_q == ST_DIV),
        .m       (in_value),
        .r       (div_r),
        .q       (div_q),
        .done    (div_done)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        odd_ok_d  = odd_ok_q;
        init_d    = 1'b1;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    m_d       = in_value;
                    div_start = 1'b1;
                    if (in_value == '0) begin
                        odd_ok_d = 1'b0;
                        state_d  = ST_EMIT_EVEN;
                    end else begin
                        state_d  = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                // Odd predecessor exists only when 3 divides m-1 exactly and the quotient is odd.
                if (div_done) begin
                    odd_ok_d = (div_r == '0) && div_q[0];
                    state_d  = ST_EMIT_EVEN;
                end
            end
            ST_EMIT_EVEN: begin
                if (out_ready) state_d = odd_ok_q ? ST_EMIT_ODD : ST_IDLE;
            end
            ST_EMIT_ODD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // init_q keeps in_ready low until the first clock edge after reset releases.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            m_q      <= '0;
            odd_ok_q <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            odd_ok_q <= odd_ok_d;
            init_q   <= init_d;
        end
    end

    always_comb begin
        in_ready  = init_q && (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        out_valid = 1'b0;
        out_value = '0;
        out_kind  = 1'b0;
        out_last  = 1'b0;
        if (state_q == ST_EMIT_EVEN) begin
            out_valid = 1'b1;
            out_value = {m_q, 1'b0};
            out_last  = !odd_ok_q;
        end else if (state_q == ST_EMIT_ODD) begin
            out_valid = 1'b1;
            out_value = {1'b0, div_q};
            out_kind  = 1'b1;
            out_last  = 1'b1;
        end
    end

endmodule

// File: doc/collatz_pred.md
COLLATZ_PRED -- requirements
Module: collatz_pred

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_value is offered.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts in_value this cycle.
REQ-005 SHALL have port in_value, input, 8 bits: unsigned m whose Collatz predecessors are enumerated.
REQ-006 SHALL have port out_valid, output, 1 bit: out beat present.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer takes beat.
REQ-008 SHALL have port out_value, output, 9 bits: unsigned predecessor value.
REQ-009 SHALL have port out_kind, output, 1 bit: 0 = even predecessor 2m, 1 = odd predecessor (m-1)/3.
REQ-010 SHALL have port out_last, output, 1 bit: final beat for the current m.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, DIV, EMIT_EVEN, EMIT_ODD.
REQ-013 IDLE: in_ready=1, out_valid=0; in_valid&in_ready latches m, loads r=m-1 (8-bit) and q=0, goes to DIV; m=0 goes straight to EMIT_EVEN with odd_ok=0.
REQ-014 DIV: in_ready=0; each cycle with r>=3: r<=r-3, q<=q+1; with r<3: odd_ok<=(r==0)&q[0], go to EMIT_EVEN.
REQ-015 DIV SHALL therefore last floor((m-1)/3)+1 cycles (1 to 85).
REQ-016 EMIT_EVEN: out_valid=1, out_value={m,1'b0} (no truncation, 9 bits), out_kind=0, out_last=!odd_ok.
REQ-017 Handshake out_valid&out_ready in EMIT_EVEN SHALL go to EMIT_ODD if odd_ok, else to IDLE.
REQ-018 EMIT_ODD: out_valid=1, out_value={1'b0,q}, out_kind=1, out_last=1; handshake goes to IDLE.
REQ-019 While out_valid=1 and out_ready=0, out_value, out_kind and out_last SHALL be held stable.
REQ-020 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored.
REQ-021 After the last handshake, in_ready SHALL be 1 on the next cycle; no combinational path from in_valid to out_*.
REQ-022 m=1 SHALL yield a single beat 2, kind 0, last 1 (q=0 is even).
REQ-023 m=4 SHALL yield predecessor 1 as the odd beat (trivial cycle is included).

Reset
REQ-024 reset_n=0 SHALL asynchronously force state IDLE, r=0, q=0, odd_ok=0, m=0.
REQ-025 During reset: in_ready=0, out_valid=0, out_value=0, out_kind=0, out_last=0, busy=0; in_ready rises on the first clock edge after reset_n deasserts.
REQ-026 Reset asserted mid-DIV or mid-EMIT SHALL discard the operation with no partial beat emitted afterwards.

Structure
REQ-027 Package collatz_pkg SHALL hold the state enum and the width constant COLLATZ_W=8.
REQ-028 The iterative subtract-by-3 divider SHALL be the sub-module collatz_div3 (start, r/q outputs, done); the rest is a single FSM.

Verification
REQ-029 m=16 -> 6 DIV cycles, then beats (32,kind0,last0) and (5,kind1,last1).
REQ-030 m=7 -> single beat (14,kind0,last1); m=0 -> single beat (0,kind0,last1) with no DIV cycle.
REQ-031 m=250 -> beats (500,kind0,last0) and (83,kind1,last1); m=200 -> single beat (400,kind0,last1).
REQ-032 m=4 with out_ready held low for 5 cycles -> beat (8,kind0) stable for all 5 cycles, then (1,kind1,last1).
REQ-033 reset_n pulsed low during DIV of m=100 -> all outputs zero immediately; next accepted m=10 -> beats (20,0,0) and (3,1,1).
REQ-034 in_valid held high throughout back-to-back m=4, m=5 -> exactly one accept per IDLE visit; m=5 yields only (10,kind0,last1).
